// File: rtl/jtl_arb_pkg.sv
// jtl_arb_pkg
//   Shared types and helpers for the JTL pulse arbiter.
//   - arb_state_t : scheduler states (BLANK, IDLE, GAP)
//   - idx_width() : width of a requester index for a given requester count
//   - cnt_width() : width of a down-counter that is loaded with at most v-1
package jtl_arb_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Width of the grant index; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a down-counter that is loaded with values up to v-1.
  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/jtl_rr_pick.sv
// jtl_rr_pick
//   Combinational round-robin priority picker. The search starts at the
//   requester named by ptr and wraps around. It returns the first requester
//   whose pending count is non-zero.
// Ports:
//   nonzero [N_REQ]  in  : one bit per requester, set when it has pending pulses
//   ptr     [IW]     in  : requester with highest priority this cycle
//   valid            out : some requester has pending pulses
//   idx     [IW]     out : selected requester (0 when valid is low)
module jtl_rr_pick
  import jtl_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] nonzero,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk the requesters in priority order starting at ptr. The sum keeps one
  // extra bit so the wrap works for requester counts that are not a power of two.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      cand = sum[IW-1:0];
      if (!valid && nonzero[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/jtl_pulse_arbiter.sv
// jtl_pulse_arbiter
//   Shares one JTL input line between N_REQ toggle-encoded SFQ pulse sources.
//   The block counts pending pulses for each requester and grants them
//   round-robin. Each grant toggles 'out' and is followed by GAP_CYCLES idle
//   cycles, so pulses stay spaced for the downstream delay cells.
// Optional feature:
//   JTL_ARB_STARTUP_BLANK_EN - when defined, reset enters a BLANK state for
//   BLANK_CYCLES cycles. Input edges are discarded during that time.
// Ports:
//   clk                  in  : clock, all state changes on its rising edge
//   rst                  in  : synchronous active-high reset
//   req_pulse [N_REQ]    in  : toggle-encoded pulse requests
//   out                  out : toggle-encoded pulse output to the JTL
//   grant_id  [clog2(N)] out : requester served by the latest out toggle
//   busy                 out : pending pulses exist or scheduler is not idle
//   overflow  [N_REQ]    out : sticky, a pulse was dropped at saturation
module jtl_pulse_arbiter
  import jtl_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int CNT_W        = 4,
  parameter  int GAP_CYCLES   = 2,
  parameter  int BLANK_CYCLES = 2,
  localparam int IW           = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse,
  output logic             out,
  output logic [IW-1:0]    grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] overflow
);

  localparam int GW = cnt_width(GAP_CYCLES);

  arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    edges;
  logic [N_REQ-1:0]    inc_v, dec_v, ovf_set;
  logic [N_REQ-1:0]    nonzero;
  logic [CNT_W-1:0]    cnt_q [N_REQ];
  logic [CNT_W-1:0]    cnt_d [N_REQ];
  logic [IW-1:0]       ptr_q, ptr_next;
  logic [GW-1:0]       gap_q, gap_d;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                grant;
  logic                accept;

`ifdef JTL_ARB_STARTUP_BLANK_EN
  localparam int BW = cnt_width(BLANK_CYCLES);
  logic [BW-1:0] blank_q, blank_d;
`endif

  // A level change between consecutive samples is one new pulse.
  assign edges = req_pulse ^ req_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nonzero[i] = (cnt_q[i] != '0);
    end
  end

  jtl_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .nonzero (nonzero),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // The pointer moves to the requester just after the one that was granted.
  assign ptr_next = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Next-state logic. A grant fires only from IDLE. GAP holds the line
  // quiet for GAP_CYCLES cycles. BLANK swallows input edges after reset.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grant   = 1'b0;
    accept  = 1'b1;
`ifdef JTL_ARB_STARTUP_BLANK_EN
    blank_d = blank_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_BLANK: begin
`ifdef JTL_ARB_STARTUP_BLANK_EN
        accept = 1'b0;
        if (blank_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          blank_d = blank_q - 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-requester increment (new pulse) and decrement (granted) strobes.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      inc_v[i] = edges[i] & accept;
      dec_v[i] = grant && (pick_idx == IW'(i));
    end
  end

  // Counter update. An increment and a decrement in the same cycle cancel.
  // An increment at the maximum is dropped and flagged.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i]   = cnt_q[i];
      ovf_set[i] = 1'b0;
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // State register. req_q is loaded from the live inputs during reset, so
  // the first cycle after reset sees no edges. busy is registered from the
  // current counters and state.
  always_ff @(posedge clk) begin
    req_q <= req_pulse;
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      overflow <= '0;
      ptr_q    <= '0;
      gap_q    <= '0;
      out      <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
`ifdef JTL_ARB_STARTUP_BLANK_EN
      state_q  <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_IDLE;
      blank_q  <= BW'(BLANK_CYCLES - 1);
`else
      state_q  <= ST_IDLE;
`endif
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      overflow <= overflow | ovf_set;
      state_q  <= state_d;
      gap_q    <= gap_d;
      busy     <= (|nonzero) || (state_q != ST_IDLE);
`ifdef JTL_ARB_STARTUP_BLANK_EN
      blank_q  <= blank_d;
`endif
      if (grant) begin
        out      <= ~out;
        grant_id <= pick_idx;
        ptr_q    <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_jtl_pulse_arbiter.sv
// tb_jtl_pulse_arbiter
//   Self-checking bench for jtl_pulse_arbiter with default parameters.
//   A behavioural model tracks pending pulses, a hold-off budget after each
//   grant, and the round-robin order. Directed and randomized scenarios
//   compare the DUT against the model and against hand-derived constants.
module tb_jtl_pulse_arbiter;

  localparam int N     = 4;
  localparam int GAP   = 2;
  localparam int BLANK = 2;
  localparam int MAXC  = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_pulse = '0;
  logic         out;
  logic [1:0]   grant_id;
  logic         busy;
  logic [N-1:0] overflow;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int           m_pend [N];
  int           m_ptr = 0;
  int           m_hold = 0;
  int           m_blank = 0;
  int           m_toggles = 0;
  int           m_dropped = 0;
  logic         m_out = 1'b0;
  logic [1:0]   m_gid = '0;
  logic         m_busy = 1'b0;
  logic [N-1:0] m_ovf = '0;
  logic [N-1:0] m_req_q = '0;

  jtl_pulse_arbiter #(
    .N_REQ        (N),
    .CNT_W        (4),
    .GAP_CYCLES   (GAP),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_pulse (req_pulse),
    .out       (out),
    .grant_id  (grant_id),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge, using the inputs as sampled at that edge.
  task automatic model_edge();
    int g;
    int c;
    bit any;
    bit was_busy;
    bit inc;
    bit dec;
    logic [N-1:0] e;
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_hold = 0; m_out = 1'b0; m_gid = '0; m_busy = 1'b0;
      m_ovf = '0; m_req_q = req_pulse;
`ifdef JTL_ARB_STARTUP_BLANK_EN
      m_blank = BLANK;
`else
      m_blank = 0;
`endif
      return;
    end
    any = 0;
    for (int i = 0; i < N; i++) any |= (m_pend[i] > 0);
    was_busy = any || (m_hold > 0) || (m_blank > 0);
    g = -1;
    if (m_blank == 0 && m_hold == 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && m_pend[c] > 0) g = c;
      end
    end
    e = req_pulse ^ m_req_q;
    m_req_q = req_pulse;
    for (int i = 0; i < N; i++) begin
      inc = e[i] && (m_blank == 0);
      dec = (g == i);
      if (inc && !dec) begin
        if (m_pend[i] == MAXC) begin
          m_ovf[i] = 1'b1;
          m_dropped++;
        end else begin
          m_pend[i]++;
        end
      end else if (dec && !inc) begin
        m_pend[i]--;
      end
    end
    if (g >= 0) begin
      m_out = ~m_out;
      m_gid = 2'(g);
      m_ptr = (g + 1) % N;
      m_hold = GAP;
      m_toggles++;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (m_blank > 0) m_blank--;
    m_busy = was_busy;
  endtask

  // One clock edge for DUT and model; returns 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_pulse = 4'b1010;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({out, grant_id, busy, overflow} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_hold: got %h expected 00", {out, grant_id, busy, overflow});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_count: out=%b busy=%b expected 0 0", out, busy);
      end
    end
  endtask

  task automatic test_single();
    logic lvl;
    logic exp_busy [5];
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(2);
    tick();
    lvl = out;
    req_pulse[2] = ~req_pulse[2];
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (out !== (t == 0 ? lvl : ~lvl)) begin
        errors++;
        $display("[TB] FAIL single_out t=%0d: got %b expected %b", t, out, (t == 0 ? lvl : ~lvl));
      end
      checks++;
      if (busy !== exp_busy[t]) begin
        errors++;
        $display("[TB] FAIL single_busy t=%0d: got %b expected %b", t, busy, exp_busy[t]);
      end
    end
    checks++;
    if (grant_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL single_grant: got %0d expected 2", grant_id);
    end
  endtask

  task automatic test_simultaneous();
    logic prev;
    logic tog;
    do_reset(2);
    tick();
    req_pulse = ~req_pulse;
    for (int t = 0; t < 12; t++) begin
      prev = out;
      tick();
      tog = (out !== prev);
      checks++;
      if (tog !== (t % 3 == 1)) begin
        errors++;
        $display("[TB] FAIL simul_toggle t=%0d: got %b expected %b", t, tog, (t % 3 == 1));
      end
      if (t % 3 == 1) begin
        checks++;
        if (grant_id !== 2'((t - 1) / 3)) begin
          errors++;
          $display("[TB] FAIL simul_grant t=%0d: got %0d expected %0d", t, grant_id, (t - 1) / 3);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic prev;
    logic tog;
    do_reset(2);
    tick();
    req_pulse[0] = ~req_pulse[0];
    tick();
    req_pulse[0] = ~req_pulse[0];
    prev = out;
    tick();
    checks++;
    if (out === prev || grant_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL same_first_grant: out=%b grant=%0d expected toggle to %b grant 0", out, grant_id, ~prev);
    end
    for (int t = 1; t <= 8; t++) begin
      prev = out;
      tick();
      tog = (out !== prev);
      checks++;
      if (tog !== (t == 3)) begin
        errors++;
        $display("[TB] FAIL same_regrant t=%0d: got %b expected %b", t, tog, (t == 3));
      end
    end
  endtask

  task automatic test_saturation();
    logic prev;
    int obs;
    do_reset(2);
    tick();
    m_dropped = 0;
    obs = 0;
    for (int t = 0; t < 30; t++) begin
      req_pulse[1] = ~req_pulse[1];
      prev = out;
      tick();
      if (out !== prev) obs++;
    end
    for (int t = 0; t < 60; t++) begin
      prev = out;
      tick();
      if (out !== prev) obs++;
    end
    checks++;
    if (overflow[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_overflow: got %b expected 1", overflow[1]);
    end
    checks++;
    if (obs !== 30 - m_dropped) begin
      errors++;
      $display("[TB] FAIL sat_total: got %0d expected %0d", obs, 30 - m_dropped);
    end
    checks++;
    if (obs > 25 || m_dropped == 0) begin
      errors++;
      $display("[TB] FAIL sat_bound: toggles %0d dropped %0d required <=25 and >0 dropped", obs, m_dropped);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_drained: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_gap();
    do_reset(2);
    tick();
    req_pulse = req_pulse ^ 4'b0011;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midgap_reset: out=%b busy=%b grant=%0d expected 0 0 0", out, busy, grant_id);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midgap_discard t=%0d: out=%b busy=%b expected 0 0", t, out, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req_pulse = req_pulse ^ N'($urandom_range(0, 15));
      tick();
      checks++;
      if ({out, grant_id, busy, overflow} !== {m_out, m_gid, m_busy, m_ovf}) begin
        errors++;
        $display("[TB] FAIL random c=%0d: got %h expected %h", c,
                 {out, grant_id, busy, overflow}, {m_out, m_gid, m_busy, m_ovf});
      end
    end
    rst = 1'b0;
  endtask

`ifdef JTL_ARB_STARTUP_BLANK_EN
  task automatic test_blank();
    do_reset(2);
    req_pulse[0] = ~req_pulse[0];
    tick();
    tick();
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blank_discard: got %b expected 0", out);
    end
    req_pulse[0] = ~req_pulse[0];
    tick();
    tick();
    checks++;
    if (out !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL blank_after: out=%b grant=%0d expected 1 0", out, grant_id);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_same_cycle();
    test_saturation();
    test_reset_mid_gap();
    test_random();
`ifdef JTL_ARB_STARTUP_BLANK_EN
    test_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtl_pulse_arbiter.md
# jtl_pulse_arbiter

Clocked scheduler that shares one basic JTL input line between several SFQ pulse requesters. Every requester and the output use toggle encoding: each transition of the line is one SFQ pulse. The block counts pending pulses per requester and grants them round-robin. It emits them on `out` with a guaranteed minimum spacing, so downstream JTL delay cells (3.5 ps each) never see overlapping pulses. It sits between pulse sources and the input of a `basic_jtl` chain.

## Interface
- `N_REQ`, default 4: number of requesters (at least 2).
- `CNT_W`, default 4: width of each pending-pulse counter; saturates at 2^CNT_W−1.
- `GAP_CYCLES`, default 2: idle cycles forced after each emitted pulse (0 is legal).
- `BLANK_CYCLES`, default 2: startup blanking length; used only when `JTL_ARB_STARTUP_BLANK_EN` is defined.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_pulse` in N_REQ: toggle-encoded pulse inputs, synchronous to `clk`.
- `out` out 1: toggle-encoded pulse output to the JTL input.
- `grant_id` out $clog2(N_REQ): requester served by the most recent `out` toggle.
- `busy` out 1: high when any counter is non-zero or the FSM is not IDLE.
- `overflow` out N_REQ: sticky flag per requester, set when a pulse is dropped at saturation.

## Operation
- Edge detect: `req_q` registers `req_pulse`. `req_pulse[i] ^ req_q[i]` at a clock edge is one new pulse for requester i. More than one transition within a cycle is not representable; only the net level change is seen.
- Counter update per requester, each cycle:
  - Increment on a new pulse.
  - Decrement when granted.
  - Both in the same cycle: count unchanged.
  - Increment at max value: count stays at max and `overflow[i]` is set.
- FSM states, in `jtl_arb_pkg`: BLANK, IDLE, GAP.
  - IDLE: if any count is non-zero, the round-robin pick selects requester g. The FSM toggles `out`, loads `grant_id`=g, decrements count[g] and moves the pointer to (g+1) mod N_REQ.
    - GAP_CYCLES>0: go to GAP and load the gap counter with GAP_CYCLES−1.
    - GAP_CYCLES=0: stay in IDLE.
  - GAP: decrement the gap counter; return to IDLE when it reaches 0. No grants occur in GAP, but counters keep accepting pulses.
  - BLANK: see Configuration.
- Round-robin: search starts at the pointer and wraps, granting the first requester with a non-zero count.
- Reset values:
  - `out`=0, `grant_id`=0, `busy`=0, `overflow`=0.
  - All counters 0, pointer 0.
  - `req_q` loaded with the current `req_pulse`, so the first cycle after reset sees no edges.
  - FSM goes to BLANK if the macro is defined, otherwise IDLE.
- Reset asserted mid-GAP or mid-burst discards all pending pulses; `out` returns to 0 (this may itself appear downstream as a pulse).

## Timing
- Pulse sampled at edge k: count visible after k. The earliest `out` toggle is at edge k+1 (latency 1 cycle, when IDLE and the requester wins).
- Minimum spacing between `out` toggles is GAP_CYCLES+1 cycles.
- Sustained throughput is 1 pulse per GAP_CYCLES+1 cycles, summed over all requesters.
- `grant_id` changes only on the same edge as an `out` toggle.
- `overflow` bits clear only on `rst`.

## Configuration
- `JTL_ARB_STARTUP_BLANK_EN` defined:
  - Reset enters BLANK for BLANK_CYCLES cycles, then goes to IDLE.
  - Input edges during BLANK are discarded, not counted.
  - `busy`=1 during BLANK.
  - This matches the startup blanking of the JTL models.
- Not defined: the BLANK state is absent and edges are counted from the first cycle after reset.

## Structure
- `jtl_arb_pkg`: state enum typedef (BLANK, IDLE, GAP) and a localparam helper for the grant index width.
- Sub-module `jtl_rr_pick`: combinational round-robin priority picker. Inputs are the non-zero vector and the pointer; outputs are `valid` and the index.
- Top level holds the counters, edge detect and FSM.

## Test plan
Default parameters unless stated.
- Reset: hold `rst` 3 cycles with `req_pulse`=4'b1010 → `out`=0, `busy`=0, `grant_id`=0, `overflow`=0, and no pulse is counted afterwards.
- Single pulse: toggle `req_pulse[2]` sampled at edge 10 → `out` 0→1 at edge 11, `grant_id`=2, `busy` low from edge 14.
- Simultaneous: toggle all four inputs at edge 5 → `out` toggles at edges 6, 9, 12, 15 with `grant_id` 0, 1, 2, 3.
- Same-cycle increment and decrement: `req_pulse[0]` toggles on the edge its grant fires → count[0] unchanged, and the next grant for requester 0 follows exactly 3 cycles later.
- Saturation: toggle `req_pulse[1]` every cycle for 30 cycles, then stop → `overflow[1]`=1 stays set. After draining, total `out` toggles equal 30 minus the dropped pulses, and never exceed 10+15.
- Blanking (macro on, BLANK_CYCLES=2): toggle `req_pulse[0]` at edge 1 after reset → no `out` toggle. A toggle at edge 3 produces an `out` toggle at edge 4. Asserting `rst` mid-GAP forces `out`=0 and counters to 0.
